// File: rtl/add_pipe.sv
// Pipelined valid/ready unsigned adder/subtractor with wrap or saturate modes
// and a saturating count of clamped results accepted downstream.
module add_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    input  logic             in_sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_sum,
    output logic             out_clamped,
    output logic [CNT_W-1:0] sat_cnt
);

    localparam int LW = WIDTH / 2;
    localparam int HW = WIDTH - LW;
    localparam int RD = (STAGES > 1) ? STAGES - 1 : 1;

    logic             advance;
    logic [WIDTH-1:0] b_eff;
    logic [LW:0]      lo_in;
    logic             front_vld;
    logic [WIDTH:0]   front_res;
    logic             front_clp;

    logic [RD-1:0]           vld_q, vld_d;
    logic [RD-1:0][WIDTH:0]  res_q, res_d;
    logic [RD-1:0]           clp_q, clp_d;
    logic [CNT_W-1:0]        sat_cnt_q, sat_cnt_d;

    // Subtraction is A + ~B + 1; the low half produces the carry into the high half.
    function automatic logic [WIDTH+1:0] finish_op(
        input logic [LW:0]   lo,
        input logic [HW-1:0] a_hi,
        input logic [HW-1:0] b_hi,
        input logic          sub,
        input logic          sat
    );
        logic [HW:0]    hi;
        logic [WIDTH:0] res;
        logic           clp;
        hi  = {1'b0, a_hi} + {1'b0, b_hi} + {{HW{1'b0}}, lo[LW]};
        res = {hi[HW] ^ sub, hi[HW-1:0], lo[LW-1:0]};
        clp = 1'b0;
        if (sat) begin
            clp = res[WIDTH];
            if (res[WIDTH]) begin
                res = sub ? '0 : {1'b0, {WIDTH{1'b1}}};
            end
        end
        return {clp, res};
    endfunction

    always_comb begin
        advance  = ~out_valid | out_ready;
        in_ready = advance;
        b_eff    = in_sub ? ~in_b : in_b;
        lo_in    = {1'b0, in_a[LW-1:0]} + {1'b0, b_eff[LW-1:0]} + {{LW{1'b0}}, in_sub};
    end

    generate
        if (STAGES == 1) begin : g_direct
            logic [WIDTH+1:0] fin;
            always_comb begin
                fin       = finish_op(lo_in, in_a[WIDTH-1:LW], b_eff[WIDTH-1:LW], in_sub, in_sat);
                front_vld = in_valid;
                front_clp = fin[WIDTH+1];
                front_res = fin[WIDTH:0];
            end
        end else begin : g_split
            // First stage registers the low-half sum; the high half completes one stage later.
            logic          s0_vld_q, s0_vld_d;
            logic [LW:0]   s0_lo_q, s0_lo_d;
            logic [HW-1:0] s0_ahi_q, s0_ahi_d;
            logic [HW-1:0] s0_bhi_q, s0_bhi_d;
            logic          s0_sub_q, s0_sub_d;
            logic          s0_sat_q, s0_sat_d;
            logic [WIDTH+1:0] fin;

            always_comb begin
                s0_vld_d = s0_vld_q;
                s0_lo_d  = s0_lo_q;
                s0_ahi_d = s0_ahi_q;
                s0_bhi_d = s0_bhi_q;
                s0_sub_d = s0_sub_q;
                s0_sat_d = s0_sat_q;
                if (advance) begin
                    s0_vld_d = in_valid;
                    s0_lo_d  = lo_in;
                    s0_ahi_d = in_a[WIDTH-1:LW];
                    s0_bhi_d = b_eff[WIDTH-1:LW];
                    s0_sub_d = in_sub;
                    s0_sat_d = in_sat;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s0_vld_q <= 1'b0;
                    s0_lo_q  <= '0;
                    s0_ahi_q <= '0;
                    s0_bhi_q <= '0;
                    s0_sub_q <= 1'b0;
                    s0_sat_q <= 1'b0;
                end else begin
                    s0_vld_q <= s0_vld_d;
                    s0_lo_q  <= s0_lo_d;
                    s0_ahi_q <= s0_ahi_d;
                    s0_bhi_q <= s0_bhi_d;
                    s0_sub_q <= s0_sub_d;
                    s0_sat_q <= s0_sat_d;
                end
            end

            always_comb begin
                fin       = finish_op(s0_lo_q, s0_ahi_q, s0_bhi_q, s0_sub_q, s0_sat_q);
                front_vld = s0_vld_q;
                front_clp = fin[WIDTH+1];
                front_res = fin[WIDTH:0];
            end
        end
    endgenerate

    // Result delay line; bubbles are stored as zeroed data so out_sum stays clean.
    always_comb begin
        vld_d = vld_q;
        res_d = res_q;
        clp_d = clp_q;
        if (advance) begin
            for (int i = RD - 1; i > 0; i--) begin
                vld_d[i] = vld_q[i-1];
                res_d[i] = res_q[i-1];
                clp_d[i] = clp_q[i-1];
            end
            vld_d[0] = front_vld;
            res_d[0] = front_vld ? front_res : '0;
            clp_d[0] = front_vld & front_clp;
        end
    end

    always_comb begin
        sat_cnt_d = sat_cnt_q;
        if (out_valid && out_ready && out_clamped && (sat_cnt_q != {CNT_W{1'b1}})) begin
            sat_cnt_d = sat_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q     <= '0;
            res_q     <= '0;
            clp_q     <= '0;
            sat_cnt_q <= '0;
        end else begin
            vld_q     <= vld_d;
            res_q     <= res_d;
            clp_q     <= clp_d;
            sat_cnt_q <= sat_cnt_d;
        end
    end

    assign out_valid   = vld_q[RD-1];
    assign out_sum     = res_q[RD-1];
    assign out_clamped = clp_q[RD-1];
    assign sat_cnt     = sat_cnt_q;

endmodule

// File: tb/tb_add_pipe.sv
// Self-checking bench for add_pipe: directed arithmetic cases, randomized
// streaming against a reference model, back-pressure and counter saturation.
module tb_add_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       in_valid, in_ready, in_sub, in_sat;
    logic [7:0] in_a, in_b;
    logic       out_valid, out_ready, out_clamped;
    logic [8:0] out_sum;
    logic [15:0] sat_cnt;

    logic       c_in_valid, c_in_ready, c_in_sub, c_in_sat;
    logic [7:0] c_in_a, c_in_b;
    logic       c_out_valid, c_out_ready, c_out_clamped;
    logic [8:0] c_out_sum;
    logic [1:0] c_sat_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    add_pipe #(.WIDTH(8), .STAGES(2), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_sat(in_sat),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_clamped(out_clamped), .sat_cnt(sat_cnt)
    );

    add_pipe #(.WIDTH(8), .STAGES(2), .CNT_W(2)) dut_c (
        .clk(clk), .rst(rst),
        .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_a(c_in_a), .in_b(c_in_b), .in_sub(c_in_sub), .in_sat(c_in_sat),
        .out_valid(c_out_valid), .out_ready(c_out_ready),
        .out_sum(c_out_sum), .out_clamped(c_out_clamped), .sat_cnt(c_sat_cnt)
    );

    // Reference result as {clamped, sum[8:0]} from plain integer arithmetic.
    function automatic logic [9:0] ref_model(input logic [7:0] a, input logic [7:0] b,
                                             input logic sub, input logic sat);
        int   r;
        logic c;
        c = 1'b0;
        if (!sub) begin
            r = int'(a) + int'(b);
            if (sat && r > 255) begin
                r = 255;
                c = 1'b1;
            end
        end else begin
            r = int'(a) - int'(b);
            if (r < 0) begin
                if (sat) begin
                    r = 0;
                    c = 1'b1;
                end else begin
                    r = r + 512;
                end
            end
        end
        return {c, 9'(r)};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        in_valid   = 1'b0;
        c_in_valid = 1'b0;
        rst        = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic one_beat(input logic [7:0] a, input logic [7:0] b, input logic sub,
                            input logic sat, output logic early, output logic vld,
                            output logic [8:0] sum, output logic clp);
        @(negedge clk);
        in_a = a; in_b = b; in_sub = sub; in_sat = sat; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        early = out_valid;
        @(negedge clk);
        vld = out_valid;
        sum = out_sum;
        clp = out_clamped;
    endtask

    task automatic test_reset();
        logic e, v, c;
        logic [8:0] s;
        #1;
        checks++;
        if (out_valid !== 1'b0 || sat_cnt !== 16'd0 || out_sum !== 9'd0) begin
            failures++;
            $display("[TB] FAIL reset_initial got valid=%b cnt=%0d sum=%0d exp 0/0/0", out_valid, sat_cnt, out_sum);
        end
        @(negedge clk);
        rst = 1'b0;
        one_beat(8'd200, 8'd100, 1'b0, 1'b1, e, v, s, c);
        @(negedge clk);
        checks++;
        if (sat_cnt !== 16'd1) begin
            failures++;
            $display("[TB] FAIL reset_precount got=%0d exp=1", sat_cnt);
        end
        in_a = 8'd250; in_b = 8'd250; in_sub = 1'b0; in_sat = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_inflight got valid=%b exp=1", out_valid);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_sum !== 9'd0 || out_clamped !== 1'b0 || sat_cnt !== 16'd0) begin
            failures++;
            $display("[TB] FAIL reset_async got valid=%b sum=%0d clp=%b cnt=%0d exp all 0",
                     out_valid, out_sum, out_clamped, sat_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_in_ready got=%b exp=1", in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("[TB] FAIL reset_no_partial cycle=%0d got valid=%b exp=0", i, out_valid);
            end
        end
    endtask

    task automatic test_directed();
        logic [7:0] ta [8] = '{8'd200, 8'd5, 8'd255, 8'd0,   8'd7, 8'd255, 8'd255, 8'd0};
        logic [7:0] tb [8] = '{8'd100, 8'd9, 8'd255, 8'd255, 8'd7, 8'd0,   8'd1,   8'd1};
        logic       ts [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic       tt [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [9:0] te [8] = '{10'h12C, 10'h1FC, 10'h1FE, 10'h101, 10'h000, 10'h0FF, 10'h2FF, 10'h200};
        logic e, v, c;
        logic [8:0] s;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            one_beat(ta[i], tb[i], ts[i], tt[i], e, v, s, c);
            checks++;
            if (e !== 1'b0 || v !== 1'b1) begin
                failures++;
                $display("[TB] FAIL directed_latency case=%0d got early=%b valid=%b exp 0/1", i, e, v);
            end
            checks++;
            if ({c, s} !== te[i]) begin
                failures++;
                $display("[TB] FAIL directed_result case=%0d got=%h exp=%h", i, {c, s}, te[i]);
            end
        end
        for (int i = 0; i < 8; i++) begin
            logic [7:0] a, b;
            logic sb, st;
            a  = 8'($urandom_range(0, 255));
            b  = 8'($urandom_range(0, 255));
            sb = 1'($urandom_range(0, 1));
            st = 1'($urandom_range(0, 1));
            one_beat(a, b, sb, st, e, v, s, c);
            checks++;
            if (v !== 1'b1 || {c, s} !== ref_model(a, b, sb, st)) begin
                failures++;
                $display("[TB] FAIL random_single a=%0d b=%0d sub=%b sat=%b got valid=%b res=%h exp=%h",
                         a, b, sb, st, v, {c, s}, ref_model(a, b, sb, st));
            end
        end
    endtask

    task automatic test_saturate();
        logic e, v, c;
        logic [8:0] s;
        do_reset();
        out_ready = 1'b1;
        one_beat(8'd200, 8'd100, 1'b0, 1'b1, e, v, s, c);
        checks++;
        if (v !== 1'b1 || s !== 9'd255 || c !== 1'b1) begin
            failures++;
            $display("[TB] FAIL sat_add got valid=%b sum=%0d clp=%b exp 1/255/1", v, s, c);
        end
        one_beat(8'd3, 8'd7, 1'b1, 1'b1, e, v, s, c);
        checks++;
        if (v !== 1'b1 || s !== 9'd0 || c !== 1'b1) begin
            failures++;
            $display("[TB] FAIL sat_sub got valid=%b sum=%0d clp=%b exp 1/0/1", v, s, c);
        end
        @(negedge clk);
        checks++;
        if (sat_cnt !== 16'd2) begin
            failures++;
            $display("[TB] FAIL sat_cnt_two got=%0d exp=2", sat_cnt);
        end
        // A clamp held at the output is only counted once it is taken.
        out_ready = 1'b0;
        one_beat(8'd250, 8'd10, 1'b0, 1'b1, e, v, s, c);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (sat_cnt !== 16'd2 || out_valid !== 1'b1) begin
                failures++;
                $display("[TB] FAIL sat_cnt_stalled got cnt=%0d valid=%b exp 2/1", sat_cnt, out_valid);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (sat_cnt !== 16'd3) begin
            failures++;
            $display("[TB] FAIL sat_cnt_release got=%0d exp=3", sat_cnt);
        end
    endtask

    task automatic test_back_to_back(input int n_beats, input int stall_at, input int stall_len);
        logic [9:0] exp_q[$];
        logic [9:0] held;
        logic [9:0] exp_v;
        logic was_stalled;
        logic need_new;
        int sent, got, cyc;
        sent = 0; got = 0; cyc = 0;
        was_stalled = 1'b0;
        need_new = 1'b1;
        held = '0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        while (got < n_beats && cyc < 200) begin
            @(negedge clk);
            cyc++;
            out_ready = !(stall_at >= 0 && cyc >= stall_at && cyc < stall_at + stall_len);
            if (need_new) begin
                if (sent < n_beats) begin
                    in_a     = 8'($urandom_range(0, 255));
                    in_b     = 8'($urandom_range(0, 255));
                    in_sub   = 1'($urandom_range(0, 1));
                    in_sat   = 1'($urandom_range(0, 1));
                    in_valid = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
            end
            #1;
            checks++;
            if (in_ready !== (!out_valid || out_ready)) begin
                failures++;
                $display("[TB] FAIL stream_in_ready cycle=%0d got=%b exp=%b", cyc, in_ready, !out_valid || out_ready);
            end
            if (was_stalled) begin
                checks++;
                if (out_valid !== 1'b1 || {out_clamped, out_sum} !== held) begin
                    failures++;
                    $display("[TB] FAIL stream_stall_hold cycle=%0d got valid=%b res=%h exp 1/%h",
                             cyc, out_valid, {out_clamped, out_sum}, held);
                end
            end
            was_stalled = out_valid && !out_ready;
            held = {out_clamped, out_sum};
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL stream_extra_beat cycle=%0d got res=%h exp none", cyc, {out_clamped, out_sum});
                end else begin
                    exp_v = exp_q.pop_front();
                    if ({out_clamped, out_sum} !== exp_v) begin
                        failures++;
                        $display("[TB] FAIL stream_result beat=%0d got=%h exp=%h", got, {out_clamped, out_sum}, exp_v);
                    end
                end
                got++;
            end
            need_new = 1'b0;
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_model(in_a, in_b, in_sub, in_sat));
                sent++;
                need_new = 1'b1;
            end
            if (!in_valid) need_new = 1'b1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (got != n_beats) begin
            failures++;
            $display("[TB] FAIL stream_timeout got beats=%0d exp=%0d", got, n_beats);
        end
        if (stall_at < 0) begin
            checks++;
            if (cyc != n_beats + 2) begin
                failures++;
                $display("[TB] FAIL stream_throughput got cycles=%0d exp=%0d", cyc, n_beats + 2);
            end
        end
    endtask

    task automatic test_counter_sat();
        do_reset();
        c_out_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            c_in_a = 8'd255; c_in_b = 8'($urandom_range(1, 255));
            c_in_sub = 1'b0; c_in_sat = 1'b1; c_in_valid = 1'b1;
            @(negedge clk);
            c_in_valid = 1'b0;
            @(negedge clk);
            @(negedge clk);
            checks++;
            if (c_sat_cnt !== 2'((k > 3) ? 3 : k)) begin
                failures++;
                $display("[TB] FAIL cnt_sat beat=%0d got=%0d exp=%0d", k, c_sat_cnt, (k > 3) ? 3 : k);
            end
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            c_in_a   = 8'($urandom_range(0, 255));
            c_in_b   = 8'($urandom_range(0, 255));
            c_in_sub = 1'($urandom_range(0, 1));
            c_in_sat = 1'b0;
            c_in_valid = 1'b1;
        end
        @(negedge clk);
        c_in_valid = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (c_sat_cnt !== 2'd3) begin
            failures++;
            $display("[TB] FAIL cnt_hold got=%0d exp=3", c_sat_cnt);
        end
    endtask

    initial begin
        in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; in_sat = 1'b0; out_ready = 1'b1;
        c_in_valid = 1'b0; c_in_a = '0; c_in_b = '0; c_in_sub = 1'b0; c_in_sat = 1'b0; c_out_ready = 1'b1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        test_reset();
        test_directed();
        test_saturate();
        test_back_to_back(20, -1, 0);
        test_back_to_back(10, 4, 4);
        test_counter_sat();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/add_pipe.md
Name: add_pipe

Overview:
- Parametrised, pipelined, valid/ready-handshaked unsigned adder/subtractor.
- Next generation of the team's registered 2-bit adder, generalised in operand width and pipeline depth.
- Adds subtract mode, saturation mode, back-pressure and a saturation-event counter.
- Used as a datapath arithmetic element between streaming stages.

Parameters:
- WIDTH, 8, operand width in bits (2..32).
- STAGES, 2, pipeline depth in register stages (1..4); equals latency.
- CNT_W, 16, width of the saturation-event counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand beat present.
- in_ready  output  1  pipe can accept a beat this cycle.
- in_a  input  WIDTH  operand A (unsigned).
- in_b  input  WIDTH  operand B (unsigned).
- in_sub  input  1  0 = A+B, 1 = A-B; sampled with the beat.
- in_sat  input  1  0 = wrap mode, 1 = saturate mode; sampled with the beat.
- out_valid  output  1  result beat present.
- out_ready  input  1  downstream accepts the result.
- out_sum  output  WIDTH+1  result; bit WIDTH is carry (add) or borrow (sub) in wrap mode.
- out_clamped  output  1  result was clamped (saturate mode only).
- sat_cnt  output  CNT_W  count of clamped results accepted downstream.

Behaviour:
- Reset (async, rst=1): all stage valid bits 0, out_valid=0, out_sum=0, out_clamped=0, sat_cnt=0.
  - in_ready=1 once rst is deasserted.
  - Reset mid-operation drops all in-flight beats; no partial output.
- Pipeline advance:
  - advance = ~out_valid | out_ready.
  - in_ready = advance (combinational).
  - Beat accepted when in_valid & in_ready.
  - When advance=0, every stage holds, including bubbles. out_sum, out_clamped and out_valid stay stable while out_valid=1 and out_ready=0.
- Latency: a beat accepted at edge N appears with out_valid=1 after edge N+STAGES-1, provided no stall.
  - Full throughput: 1 beat/cycle with out_ready held at 1.
  - Bubbles propagate as valid=0 and are never emitted.
- Arithmetic, wrap mode:
  - add: out_sum = A + B at full WIDTH+1 bits.
  - sub: out_sum[WIDTH-1:0] = (A - B) mod 2^WIDTH; out_sum[WIDTH] = 1 iff A < B.
  - out_clamped = 0.
- Arithmetic, saturate mode:
  - add: if A + B > 2^WIDTH - 1, out_sum = 2^WIDTH - 1 and out_clamped=1; else exact sum with out_clamped=0.
  - sub: if A < B, out_sum = 0 and out_clamped=1; else A - B.
  - out_sum[WIDTH] is always 0.
- Carry chain: may be split across stages (low half first), but the result must be bit-identical to the unsplit computation for all inputs.
- sat_cnt:
  - Increments by 1 on each output handshake (out_valid & out_ready) with out_clamped=1.
  - Saturates at 2^CNT_W - 1; never wraps.
  - Clamps that are stalled, not yet transferred, are not counted.
- Simultaneous events: on the same edge the output beat leaves, a new beat enters and all stages shift. No beat is lost or duplicated.
- in_sub and in_sat travel with their beat; changing them between beats has no effect on in-flight data.
- STAGES=1: single register stage; in_ready still follows the advance rule.

Test Plan:
- Reset, WIDTH=8, STAGES=2, out_ready=1: rst pulse mid-cycle -> out_valid, sat_cnt, out_sum = 0 immediately (async). in_ready=1 after release.
- Wrap add: A=200, B=100, sub=0, sat=0 -> two edges later out_sum=300 (9'h12C), out_clamped=0.
- Wrap sub: A=5, B=9 -> out_sum=9'h1FC (borrow=1, low byte 252), out_clamped=0.
- Saturate: A=200, B=100, sat=1 -> out_sum=255, out_clamped=1. Then A=3, B=7, sub=1, sat=1 -> out_sum=0, out_clamped=1; sat_cnt=2 after both handshakes.
- Back-pressure: stream 10 random beats, out_ready low for 4 cycles mid-stream.
  - in_ready=0 during the stall.
  - out_sum stable while stalled.
  - All 10 results emitted in order and match the reference model (a+b, or a-b, with clamp rules).
- Counter saturation, CNT_W=2: 5 clamped beats -> sat_cnt reaches 3 and holds. Random wrap-mode beats then leave it unchanged.
